// File: rtl/multi_song_reader_pkg.sv
// Shared definitions for the multi-song note sequencer: FSM state
// encoding and helpers that derive widths and ROM field positions.
package multi_song_reader_pkg;

  // One-hot sequencer states
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_FETCH   = 5'b00010,
    ST_WAIT    = 5'b00100,
    ST_END     = 5'b01000,
    ST_STOPPED = 5'b10000
  } state_t;

  function automatic int song_w(input int num_songs);
    return $clog2(num_songs);
  endfunction

  function automatic int idx_w(input int notes_per_song);
    return $clog2(notes_per_song);
  endfunction

  // ROM word is {note, duration}; note occupies the upper field
  function automatic int note_msb(input int note_w, input int dur_w);
    return note_w + dur_w - 1;
  endfunction

  function automatic int dur_msb(input int dur_w);
    return dur_w - 1;
  endfunction

endpackage

// File: rtl/dff_cells.sv
// Register library cells: dffr (sync reset) and dffre (sync reset + enable).
module dffr #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

endmodule

module dffre #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load-enabled register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rom_fetch_timer.sv
// Down-counter that measures the ROM read latency. start loads
// ROM_LATENCY, clear parks it at zero, hold freezes it; done is high when
// the count has reached zero, i.e. the ROM word is valid.
module rom_fetch_timer #(
  parameter int ROM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = $clog2(ROM_LATENCY + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: start beats clear beats hold; otherwise count down to zero
  always_comb begin
    cnt_nxt = cnt;
    if (start)                      cnt_nxt = CNT_W'(ROM_LATENCY);
    else if (clear)                 cnt_nxt = '0;
    else if (!hold && cnt != '0)    cnt_nxt = cnt - CNT_W'(1);
  end

  dffr #(.W(CNT_W)) u_cnt (.clk(clk), .reset(reset), .d(cnt_nxt), .q(cnt));

  assign done = (cnt == '0);

endmodule

// File: rtl/multi_song_reader.sv
// Note sequencer: walks one song's {note,duration} entries in an external
// ROM and hands each note to the note player via new_note/note_done.
// Supports pause, looping, a zero-duration terminator and song switching.
module multi_song_reader
  import multi_song_reader_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  parameter int NOTE_W         = 6,
  parameter int DUR_W          = 6,
  parameter int ROM_LATENCY    = 1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             play,
  input  logic [$clog2(NUM_SONGS)-1:0]                     song,
  input  logic                                             loop,
  input  logic                                             note_done,
  output logic [$clog2(NUM_SONGS)+$clog2(NOTES_PER_SONG)-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]                          rom_data,
  output logic [NOTE_W-1:0]                                note,
  output logic [DUR_W-1:0]                                 duration,
  output logic                                             new_note,
  output logic                                             song_done,
  output logic                                             busy
);

  localparam int SONG_W   = song_w(NUM_SONGS);
  localparam int IDX_W    = idx_w(NOTES_PER_SONG);
  localparam int NOTE_MSB = note_msb(NOTE_W, DUR_W);
  localparam int DUR_MSB  = dur_msb(DUR_W);

  logic [4:0]              state_q;
  state_t                  state;
  state_t                  state_nxt;
  logic [SONG_W-1:0]       cur_song, song_nxt;
  logic [IDX_W-1:0]        index, idx_nxt;
  logic [NOTE_MSB:0]       note_dur;
  logic                    load_note;
  logic                    new_note_nxt;
  logic                    song_done_nxt;
  logic                    t_start, t_done;
  logic                    switch_req;
  logic                    last_idx;

  assign state      = state_t'(state_q);
  assign switch_req = play && (song != cur_song);
  assign last_idx   = (index == IDX_W'(NOTES_PER_SONG - 1));

  // Sequencer next-state and output decisions (pause > switch > note_done)
  always_comb begin
    state_nxt     = state;
    song_nxt      = cur_song;
    idx_nxt       = index;
    load_note     = 1'b0;
    new_note_nxt  = 1'b0;
    song_done_nxt = 1'b0;
    t_start       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (play) begin
          song_nxt  = song;
          idx_nxt   = '0;
          state_nxt = ST_FETCH;
          t_start   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!play) begin
          // Reloading while paused both freezes and restarts the latency count
          t_start = 1'b1;
        end else if (switch_req) begin
          song_nxt = song;
          idx_nxt  = '0;
          t_start  = 1'b1;
        end else if (t_done) begin
          if (rom_data[DUR_MSB:0] == '0) begin
            state_nxt     = ST_END;
            song_done_nxt = 1'b1;
          end else begin
            load_note    = 1'b1;
            new_note_nxt = 1'b1;
            state_nxt    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (play) begin
          if (switch_req) begin
            song_nxt  = song;
            idx_nxt   = '0;
            state_nxt = ST_FETCH;
            t_start   = 1'b1;
          end else if (note_done) begin
            if (last_idx) begin
              state_nxt     = ST_END;
              song_done_nxt = 1'b1;
            end else begin
              idx_nxt   = index + IDX_W'(1);
              state_nxt = ST_FETCH;
              t_start   = 1'b1;
            end
          end
        end
      end
      ST_END: begin
        if (loop && play) begin
          idx_nxt   = '0;
          state_nxt = ST_FETCH;
          t_start   = 1'b1;
        end else begin
          state_nxt = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        if (!play) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers
  dffr #(.W(5), .RST_VAL(5'(ST_IDLE))) u_state (.clk(clk), .reset(reset), .d(5'(state_nxt)), .q(state_q));
  dffr #(.W(SONG_W)) u_song  (.clk(clk), .reset(reset), .d(song_nxt),      .q(cur_song));
  dffr #(.W(IDX_W))  u_index (.clk(clk), .reset(reset), .d(idx_nxt),       .q(index));
  dffr #(.W(1))      u_nn    (.clk(clk), .reset(reset), .d(new_note_nxt),  .q(new_note));
  dffr #(.W(1))      u_sd    (.clk(clk), .reset(reset), .d(song_done_nxt), .q(song_done));

  // Note/duration output register, loaded only on an accepted ROM word
  dffre #(.W(NOTE_MSB + 1)) u_note (
    .clk(clk), .reset(reset), .en(load_note), .d(rom_data), .q(note_dur)
  );

  rom_fetch_timer #(.ROM_LATENCY(ROM_LATENCY)) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (t_start),
    .hold  (!play),
    .clear ((state == ST_IDLE) || (state == ST_STOPPED)),
    .done  (t_done)
  );

  assign rom_addr = {cur_song, index};
  assign note     = note_dur[NOTE_MSB:DUR_W];
  assign duration = note_dur[DUR_MSB:0];
  assign busy     = (state == ST_FETCH) || (state == ST_WAIT);

endmodule

// File: tb/tb_multi_song_reader.sv
// Randomized bench for multi_song_reader: two instances (ROM latency 1 and 3)
// share play/song/loop/reset and are compared every cycle against a
// behavioural model of the sequencer rules.
module tb_multi_song_reader;

  localparam int NS = 4;
  localparam int NP = 32;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int AW = 7;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_WAIT  = 2;
  localparam int M_END   = 3;
  localparam int M_STOP  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          play;
  logic [1:0]    song;
  logic          loop;
  logic          note_done [2];
  logic [AW-1:0] rom_addr  [2];
  logic [11:0]   rom_data  [2];
  logic [NW-1:0] note      [2];
  logic [DW-1:0] duration  [2];
  logic          new_note  [2];
  logic          song_done [2];
  logic          busy      [2];

  multi_song_reader #(.NUM_SONGS(NS), .NOTES_PER_SONG(NP), .NOTE_W(NW), .DUR_W(DW), .ROM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .play(play), .song(song), .loop(loop),
    .note_done(note_done[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .note(note[0]), .duration(duration[0]), .new_note(new_note[0]),
    .song_done(song_done[0]), .busy(busy[0])
  );

  multi_song_reader #(.NUM_SONGS(NS), .NOTES_PER_SONG(NP), .NOTE_W(NW), .DUR_W(DW), .ROM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .play(play), .song(song), .loop(loop),
    .note_done(note_done[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .note(note[1]), .duration(duration[1]), .new_note(new_note[1]),
    .song_done(song_done[1]), .busy(busy[1])
  );

  // Song ROM with 1-cycle and 3-cycle read pipelines
  logic [11:0] mem [NS*NP];
  logic [11:0] pipe_a;
  logic [11:0] pipe_b [3];

  always @(posedge clk) begin
    pipe_a    <= mem[rom_addr[0]];
    pipe_b[0] <= mem[rom_addr[1]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign rom_data[0] = pipe_a;
  assign rom_data[1] = pipe_b[2];

  // Reference model state, one set per instance
  int lat    [2];
  int m_mode [2];
  int m_cs   [2];
  int m_ix   [2];
  int m_age  [2];
  int m_note [2];
  int m_dur  [2];
  int m_nn   [2];
  int m_sd   [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Predict the effect of the coming clock edge from the current inputs
  task automatic step_model(input int k);
    logic [11:0] e;
    m_nn[k] = 0;
    m_sd[k] = 0;
    if (reset) begin
      m_mode[k] = M_IDLE; m_cs[k] = 0; m_ix[k] = 0; m_age[k] = 0;
      m_note[k] = 0; m_dur[k] = 0;
    end else begin
      case (m_mode[k])
        M_IDLE: if (play) begin
          m_cs[k] = int'(song); m_ix[k] = 0; m_age[k] = 0; m_mode[k] = M_FETCH;
        end
        M_FETCH: begin
          if (!play) m_age[k] = 0;
          else if (int'(song) != m_cs[k]) begin
            m_cs[k] = int'(song); m_ix[k] = 0; m_age[k] = 0;
          end else if (m_age[k] == lat[k]) begin
            e = mem[m_cs[k]*NP + m_ix[k]];
            if (e[5:0] == 6'd0) begin
              m_mode[k] = M_END; m_sd[k] = 1;
            end else begin
              m_note[k] = int'(e[11:6]); m_dur[k] = int'(e[5:0]);
              m_nn[k] = 1; m_mode[k] = M_WAIT;
            end
          end else m_age[k] = m_age[k] + 1;
        end
        M_WAIT: if (play) begin
          if (int'(song) != m_cs[k]) begin
            m_cs[k] = int'(song); m_ix[k] = 0; m_age[k] = 0; m_mode[k] = M_FETCH;
          end else if (note_done[k]) begin
            if (m_ix[k] == NP-1) begin
              m_mode[k] = M_END; m_sd[k] = 1;
            end else begin
              m_ix[k] = m_ix[k] + 1; m_age[k] = 0; m_mode[k] = M_FETCH;
            end
          end
        end
        M_END: begin
          if (loop && play) begin
            m_ix[k] = 0; m_age[k] = 0; m_mode[k] = M_FETCH;
          end else m_mode[k] = M_STOP;
        end
        M_STOP: if (!play) m_mode[k] = M_IDLE;
        default: m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_dut(input int k);
    string p;
    p = (k == 0) ? "lat1" : "lat3";
    check({p, " rom_addr"},  32'(rom_addr[k]),  32'(m_cs[k]*NP + m_ix[k]));
    check({p, " note"},      32'(note[k]),      32'(m_note[k]));
    check({p, " duration"},  32'(duration[k]),  32'(m_dur[k]));
    check({p, " new_note"},  32'(new_note[k]),  32'(m_nn[k]));
    check({p, " song_done"}, 32'(song_done[k]), 32'(m_sd[k]));
    check({p, " busy"},      32'(busy[k]),
          32'((m_mode[k] == M_FETCH) || (m_mode[k] == M_WAIT)));
  endtask

  initial begin
    int tog_mod;
    int sw_mod;
    int nd_mod;
    logic [5:0] d;

    // Song 0 ends early at entry 5, song 1 is full length, others random
    for (int i = 0; i < NS*NP; i++) begin
      d = 6'($urandom_range(1, 63));
      if (i >= 2*NP && (i % NP) != 0 && $urandom_range(0, 23) == 0) d = 6'd0;
      if (i == 5) d = 6'd0;
      mem[i] = {6'($urandom_range(0, 63)), d};
    end

    lat[0] = 1;
    lat[1] = 3;
    reset = 1'b1; play = 1'b0; song = 2'd2; loop = 1'b0;
    note_done[0] = 1'b0; note_done[1] = 1'b0;

    for (int seg = 0; seg < 10; seg++) begin
      if (seg == 0) begin
        tog_mod = 0; sw_mod = 0; nd_mod = 2;
      end else begin
        case ($urandom_range(0, 2))
          0:       tog_mod = 8;
          1:       tog_mod = 60;
          default: tog_mod = 500;
        endcase
        sw_mod = ($urandom_range(0, 1) == 0) ? 0 : 150;
        nd_mod = $urandom_range(1, 4);
        song   = 2'($urandom_range(0, 3));
        loop   = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 700; c++) begin
        if (seg == 0) begin
          reset = (c < 2);
          play  = (c >= 2);
        end else begin
          reset = ($urandom_range(0, 399) == 0);
          if (tog_mod != 0 && $urandom_range(1, tog_mod) == 1) play = ~play;
          if (sw_mod != 0 && $urandom_range(1, sw_mod) == 1) song = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 199) == 0) loop = ~loop;
        end
        note_done[0] = ($urandom_range(0, nd_mod) == 0);
        note_done[1] = ($urandom_range(0, nd_mod) == 0);
        step_model(0);
        step_model(1);
        @(negedge clk);
        compare_dut(0);
        compare_dut(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
